// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO over a registered-read RAM,
// with read prefetch into a 2-entry output buffer that hides the RAM read latency.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] slot0, slot1, slot0_n, slot1_n;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_n, count, count_n;
    logic [1:0]            slot_cnt, slot_cnt_n, occ, land_pos;
    logic                  inflight, s_ready, push, pop, rd_en;

    always_comb begin
        push       = i_s_valid && s_ready;
        pop        = (slot_cnt != 2'd0) && i_m_ready;
        occ        = slot_cnt + {1'b0, inflight} - {1'b0, pop};
        rd_en      = (ram_cnt != '0) && (occ < 2'd2);
        land_pos   = slot_cnt - {1'b0, pop};
        // the landing read goes to the first free slot after this cycle's pop
        slot0_n    = (inflight && land_pos == 2'd0) ? rd_q :
                     (pop && slot_cnt == 2'd2)      ? slot1 : slot0;
        slot1_n    = (inflight && land_pos == 2'd1) ? rd_q : slot1;
        slot_cnt_n = land_pos + {1'b0, inflight};
        ram_cnt_n  = (push && !rd_en) ? ram_cnt + CNT_ONE :
                     (rd_en && !push) ? ram_cnt - CNT_ONE : ram_cnt;
        count_n    = (push && !pop) ? count + CNT_ONE :
                     (pop && !push) ? count - CNT_ONE : count;
    end

    // RAM has no reset: discarded entries are never read back
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_s_data;
        if (rd_en)
            rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
            slot_cnt <= 2'd0;
            count    <= '0;
            s_ready  <= 1'b1;
        end else begin
            wr_ptr   <= push ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr   <= rd_en ? rd_ptr + PTR_ONE : rd_ptr;
            ram_cnt  <= ram_cnt_n;
            inflight <= rd_en;
            slot0    <= slot0_n;
            slot1    <= slot1_n;
            slot_cnt <= slot_cnt_n;
            count    <= count_n;
            s_ready  <= count_n < DEPTH;
        end
    end

    assign o_s_ready = s_ready;
    assign o_m_valid = slot_cnt != 2'd0;
    assign o_m_data  = slot0;
    assign o_count   = count;
    assign o_full    = count == DEPTH;
    assign o_empty   = count == '0;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: randomized and directed stimulus against a queue model of the FWFT FIFO.
module tb_sync_fifo_fwft;
    typedef struct {
        logic [7:0] d;
        int         t;
    } ent_t;

    logic       clk, rst_n, s_valid, s_ready, m_valid, m_ready, full, empty;
    logic [7:0] s_data, m_data;
    logic [6:0] count;
    int         checks = 0, errors = 0, cyc = 0, idx;
    ent_t       q[$];
    logic [7:0] last = 8'h00;

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .i_s_data(s_data), .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // an entry is visible at the head two edges after the edge that accepted it
    function automatic bit exp_valid();
        return q.size() != 0 && (cyc - q[0].t >= 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit pv, pp;
        if (!rst_n) begin
            q.delete();
            last = 8'h00;
        end else begin
            pp = exp_valid() && m_ready;
            pv = s_valid && q.size() < 64;
            if (pp) begin
                last = q[0].d;
                void'(q.pop_front());
            end
            cyc++;
            if (pv)
                q.push_back('{s_data, cyc});
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), q.size());
        chk("s_ready", 32'(s_ready), 32'(q.size() < 64));
        chk("full", 32'(full), 32'(q.size() == 64));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("m_valid", 32'(m_valid), 32'(exp_valid()));
        chk("m_data", 32'(m_data), 32'(exp_valid() ? q[0].d : last));
    end

    always @(posedge clk)
        if (rst_n && dut.push && dut.rd_en)
            chk("ptr_collision", 32'(dut.wr_ptr != dut.rd_ptr), 1);

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = r;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 1);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        reset_vals("por");
        rst_n = 1'b1;
        // single word latency
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("lat_edge0_valid", 32'(m_valid), 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("lat_edge1_valid", 32'(m_valid), 0);
        drive(1'b0, 8'h00, 1'b1);
        chk("lat_edge2_valid", 32'(m_valid), 1);
        chk("lat_edge2_data", 32'(m_data), 32'hA5);
        drive(1'b0, 8'h00, 1'b0);
        chk("single_pop_empty", 32'(empty), 1);
        chk("single_pop_count", 32'(count), 0);
        // fill to full, one rejected push, ordered drain
        for (int i = 0; i < 64; i++)
            drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'h99, 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_s_ready", 32'(s_ready), 0);
        chk("fill_count", 32'(count), 64);
        drive(1'b0, 8'h00, 1'b0);
        chk("overflow_count", 32'(count), 64);
        idx = 0;
        for (int k = 0; k < 100 && idx < 64; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (m_valid) begin
                chk("drain_order", 32'(m_data), idx);
                idx++;
            end
        end
        chk("drain_all", idx, 64);
        drive(1'b0, 8'h00, 1'b0);
        chk("drain_empty", 32'(empty), 1);
        // full with simultaneous push and pop
        for (int i = 0; i < 64; i++)
            drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'h11, 1'b1);
        drive(1'b1, 8'h22, 1'b0);
        chk("fullpop_count", 32'(count), 63);
        chk("fullpop_s_ready", 32'(s_ready), 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("fullpop_refill_count", 32'(count), 64);
        chk("fullpop_refill_full", 32'(full), 1);
        for (int k = 0; k < 70; k++)
            drive(1'b0, 8'h00, 1'b1);
        // streaming: steady state after the 2-edge fill latency
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            if (i >= 3) begin
                chk("stream_valid", 32'(m_valid), 1);
                chk("stream_count", 32'(count), 3);
            end
        end
        for (int k = 0; k < 6; k++)
            drive(1'b0, 8'h00, 1'b1);
        // random traffic
        for (int i = 0; i < 10000; i++)
            drive(1'(($urandom_range(0, 1))), 8'($urandom), 1'(($urandom_range(0, 1))));
        for (int k = 0; k < 80; k++)
            drive(1'b0, 8'h00, 1'b1);
        // async reset with 10 entries held and a read in flight
        for (int i = 0; i < 10; i++)
            drive(1'b1, 8'(8'h10 + i), 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_ready = 1'b0;
        #1;
        reset_vals("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8 && !m_valid; k++)
            drive(1'b0, 8'h00, 1'b0);
        chk("post_rst_valid", 32'(m_valid), 1);
        chk("post_rst_data", 32'(m_data), 32'h3C);
        chk("post_rst_count", 32'(count), 1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", 32'(empty), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
